// File: rtl/demux_sched_pkg.sv
// Shared types and constants for the demux select scheduler.
package demux_sched_pkg;
    localparam int NUM_OUT = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;
endpackage

// File: rtl/rr_pick8.sv
// Round-robin pick: first set req bit at or after ptr, searching upward with wrap.
// Latency: combinational. Backpressure: none, pure function of req and ptr.
module rr_pick8
    import demux_sched_pkg::*;
(
    input  logic [NUM_OUT-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               any,
    output logic [SEL_W-1:0]   idx
);
    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        any  = |req;
        idx  = ptr;
        cand = ptr;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            cand = ptr + SEL_W'(i);
            if (req[cand]) begin
                idx = cand;
            end
        end
    end
endmodule

// File: rtl/demux_sel_scheduler.sv
// Time-slot round-robin scheduler driving a 1-to-8 demux select; DEMUX_SCHED_GAP_EN adds one idle GAP cycle per slot end.
// Latency: one cycle from req to route_en; slots last SLOT_LEN cycles unless the owner drops req early.
// Backpressure: none; a requester holds req to keep its slot and drops it to release the slot early.
module demux_sel_scheduler #(
    parameter int SLOT_LEN = 4,
    parameter int NUM_OUT  = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_OUT-1:0]               req,
    output logic [demux_sched_pkg::SEL_W-1:0] sel,
    output logic                             route_en,
    output logic [NUM_OUT-1:0]               grant,
    output logic                             slot_done,
    output logic                             busy
);
    import demux_sched_pkg::*;

    localparam int CNT_W = 4;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] pick_ptr;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_any;
    logic             slot_end;

    // slot_done is decoded from registered state and the live req so an early release ends the slot in the same cycle.
    assign slot_end  = (state == GRANT) && ((cnt == '0) || !req[sel]);
    assign slot_done = slot_end;
    assign busy      = (state != IDLE);
    assign pick_ptr  = slot_end ? sel + SEL_W'(1) : ptr;

    rr_pick8 u_pick (
        .req (req),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            sel      <= '0;
            route_en <= 1'b0;
            grant    <= '0;
            cnt      <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        sel      <= pick_idx;
                        route_en <= 1'b1;
                        grant    <= {{(NUM_OUT-1){1'b0}}, 1'b1} << pick_idx;
                        cnt      <= CNT_W'(SLOT_LEN - 1);
                    end
                end
                GRANT: begin
                    if (slot_end) begin
                        ptr <= sel + SEL_W'(1);
`ifdef DEMUX_SCHED_GAP_EN
                        state    <= GAP;
                        route_en <= 1'b0;
                        grant    <= '0;
`else
                        if (pick_any) begin
                            sel      <= pick_idx;
                            route_en <= 1'b1;
                            grant    <= {{(NUM_OUT-1){1'b0}}, 1'b1} << pick_idx;
                            cnt      <= CNT_W'(SLOT_LEN - 1);
                        end else begin
                            state    <= IDLE;
                            route_en <= 1'b0;
                            grant    <= '0;
                        end
`endif
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
`ifdef DEMUX_SCHED_GAP_EN
                GAP: begin
                    if (pick_any) begin
                        state    <= GRANT;
                        sel      <= pick_idx;
                        route_en <= 1'b1;
                        grant    <= {{(NUM_OUT-1){1'b0}}, 1'b1} << pick_idx;
                        cnt      <= CNT_W'(SLOT_LEN - 1);
                    end else begin
                        state <= IDLE;
                    end
                end
`endif
                default: begin
                    state    <= IDLE;
                    route_en <= 1'b0;
                    grant    <= '0;
                end
            endcase
        end
    end
endmodule
